// File: rtl/game_round_ctrl.sv
// Round sequencer for the reaction game: button conditioning, round control, verdict latch, score.
// Optional build macro GAME_AUTO_RESTART_EN: HOLD ends by itself instead of waiting for a press.
module game_round_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESULT_TIMEOUT  = 8,
  parameter int HOLD_CYCLES     = 16,
  parameter int SCORE_W         = 4,
  parameter int MAX_SCORE       = 9
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Button,
  input  logic               Win,
  input  logic               Lose,
  output logic               Stop,
  output logic               RoundReset,
  output logic               WinLed,
  output logic               LoseLed,
  output logic [SCORE_W-1:0] Score,
  output logic [SCORE_W-1:0] Misses,
  output logic               GameOver
);
  localparam int TMAX  = (RESULT_TIMEOUT > HOLD_CYCLES) ? RESULT_TIMEOUT : HOLD_CYCLES;
  localparam int TMR_W = $clog2(TMAX + 2);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TMR_W-1:0]   TMR_SAT   = '1;
  localparam logic [TMR_W-1:0]   TO_LAST   = TMR_W'(RESULT_TIMEOUT - 1);
  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] MISS_MAX  = '1;

  typedef enum logic [2:0] {NEWROUND, RUN, STOP, HOLD, OVER} state_t;

  state_t             state, state_nxt;
  logic               sync_p0, sync_p1, btn_lvl;
  logic [DB_W-1:0]    db_cnt;
  logic               db_flip, press;
  logic [TMR_W-1:0]   timer;
  logic               win_led, lose_led;
  logic               win_hit, loss_hit, hold_exit;

  // Synchronizer and debouncer: press fires on the same edge the level rises
  assign db_flip = (sync_p1 != btn_lvl) && (db_cnt == DB_LAST);
  assign press   = db_flip && sync_p1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      btn_lvl <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync_p0 <= Button;
      sync_p1 <= sync_p0;
      if (sync_p1 == btn_lvl) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        btn_lvl <= sync_p1;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign win_hit  = Win && !Lose;
  assign loss_hit = Lose || (timer == TO_LAST);

`ifdef GAME_AUTO_RESTART_EN
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  assign hold_exit = (timer == HOLD_LAST);
`else
  localparam logic [TMR_W-1:0] HOLD_MIN = TMR_W'(HOLD_CYCLES);
  assign hold_exit = (timer >= HOLD_MIN) && press;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) state <= NEWROUND;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NEWROUND: state_nxt = RUN;
      RUN:      if (press) state_nxt = STOP;
      STOP:     if (win_hit || loss_hit) state_nxt = HOLD;
      HOLD:     if (hold_exit) state_nxt = (Score == SCORE_MAX) ? OVER : NEWROUND;
      OVER:     state_nxt = OVER;
      default:  state_nxt = NEWROUND;
    endcase
  end

  // Timer restarts on every state change; verdict and counters update only from STOP
  always_ff @(posedge Clock) begin
    if (Reset) begin
      timer    <= '0;
      win_led  <= 1'b0;
      lose_led <= 1'b0;
      Score    <= '0;
      Misses   <= '0;
    end else begin
      if (state_nxt != state)  timer <= '0;
      else if (timer != TMR_SAT) timer <= timer + 1'b1;
      if (state == STOP) begin
        if (win_hit) begin
          win_led <= 1'b1;
          if (Score != SCORE_MAX) Score <= Score + 1'b1;
        end else if (loss_hit) begin
          lose_led <= 1'b1;
          if (Misses != MISS_MAX) Misses <= Misses + 1'b1;
        end
      end
      if (state == HOLD && state_nxt == NEWROUND) begin
        win_led  <= 1'b0;
        lose_led <= 1'b0;
      end
    end
  end

  always_comb begin
    Stop       = 1'b0;
    RoundReset = 1'b0;
    GameOver   = 1'b0;
    WinLed     = win_led;
    LoseLed    = lose_led;
    case (state)
      NEWROUND: RoundReset = !Reset;
      STOP, HOLD: Stop = 1'b1;
      OVER: begin
        Stop     = 1'b1;
        GameOver = 1'b1;
        WinLed   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
Round sequencer for the reaction game: sits on the player side of the counter/win-lose datapath. It turns the raw push-button into a clean single Stop request, drives the per-round counter reset, and latches the Win/Lose verdict returned by the win/lose logic. It also keeps a running score and ends the game at a target score.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a new button level (>=1)
RESULT_TIMEOUT, 8, cycles in STOP waiting for Win/Lose before forcing a loss (>=1)
HOLD_CYCLES, 16, cycles the verdict is displayed before the next round (>=1)
SCORE_W, 4, width of Score and Misses
MAX_SCORE, 9, Score value that ends the game (1..2^SCORE_W-1)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high; whole block to reset state
Button  in  1  raw asynchronous push-button, active-high
Win  in  1  verdict from win/lose logic, valid while Stop=1
Lose  in  1  verdict from win/lose logic, valid while Stop=1
Stop  out  1  freeze request to win/lose logic
RoundReset  out  1  one-cycle pulse that restarts both counters
WinLed  out  1  latched win verdict of current round
LoseLed  out  1  latched loss verdict of current round
Score  out  SCORE_W  rounds won, saturating at MAX_SCORE
Misses  out  SCORE_W  rounds lost, saturating at all-ones
GameOver  out  1  high once Score reaches MAX_SCORE

Behaviour:
- Reset values: Stop=0, RoundReset=0, WinLed=0, LoseLed=0, Score=0, Misses=0, GameOver=0, state=NEWROUND, debounced level=0, synchronizer=0, all timers=0.
- Input path: Button -> 2-flop synchronizer -> debouncer. The debounced level takes the synchronized value only after it has differed from the current level for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count. Press = 0->1 transition of the debounced level; one-cycle internal event. Holding the button never generates a second press.
- Minimum latency from a clean Button rise to a press event: 2 + DEBOUNCE_CYCLES cycles.
- States:
  - NEWROUND: RoundReset=1 for exactly one cycle; WinLed/LoseLed cleared; Stop=0. Next state: RUN.
  - RUN: Stop=0. On a press event, go to STOP. A press in any other state is discarded. It is never queued.
  - STOP: Stop=1; timer counts from 0. When Win=1 and Lose=0 are sampled: WinLed<=1, Score+1, next state HOLD. When Lose=1 is sampled (including Win=Lose=1): LoseLed<=1, Misses+1, next state HOLD. If the timer reaches RESULT_TIMEOUT with neither input high: treat as a loss (LoseLed<=1, Misses+1), next state HOLD.
  - HOLD: Stop=1, LEDs held; timer counts HOLD_CYCLES. Exit condition depends on GAME_AUTO_RESTART_EN. If Score==MAX_SCORE, go to OVER; otherwise go to NEWROUND.
  - OVER: Stop=1, GameOver=1, WinLed=1. Stays here until Reset; presses are ignored.
- Score saturates at MAX_SCORE. Misses saturates at 2^SCORE_W-1 with no wrap.
- Win/Lose are ignored outside STOP.
- Reset mid-round, in any state, overrides everything in that cycle and returns the block to reset values. The first cycle after reset is NEWROUND, so a RoundReset pulse always follows a Reset.
- Only one verdict is latched per round; the first qualifying cycle in STOP wins.

Optional Feature:
GAME_AUTO_RESTART_EN
- Defined: HOLD exits automatically after HOLD_CYCLES cycles.
- Undefined: HOLD waits at least HOLD_CYCLES cycles, then exits only on the next press event. Presses during the first HOLD_CYCLES cycles are discarded. The press that exits HOLD does not also stop the next round.

Test Plan:
- Reset 3 cycles, release -> next cycle RoundReset=1 for 1 cycle; all other outputs 0; state RUN after.
- Button high 2 cycles then low (DEBOUNCE_CYCLES=4) -> no press, Stop stays 0. Button held high 10 cycles -> Stop=1 exactly 6 cycles after Button rise, and one press only.
- In STOP, drive Win=1 on the 3rd cycle -> WinLed=1, Score 0->1; with auto-restart, RoundReset pulses HOLD_CYCLES=16 cycles later.
- In STOP, keep Win=Lose=0 for 8 cycles -> LoseLed=1, Misses=1, Score unchanged. Separately, Win=Lose=1 -> counted as a loss.
- Nine consecutive wins with MAX_SCORE=9 -> after the 9th HOLD, GameOver=1, Stop=1, Score=9; further presses give no change; Reset clears to 0.
- Assert Reset during STOP and during HOLD -> Stop, LEDs and Score return to 0 on the next edge, then a RoundReset pulse follows.
